// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - instruction fetch sequencer: PC register, imem handshake, IF/ID slot, stall/redirect handling
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    output logic        if_valid_o,
    output logic [31:0] if_pc_o,
    output logic [31:0] if_inst_o,
    output logic        flush_if_id_o,
    output logic        flush_id_ex_o
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] redir_q;
    logic        drop_q;
    logic        buf_valid_q;
    logic [31:0] buf_pc_q;
    logic [31:0] buf_inst_q;
    logic        if_valid_q;
    logic [31:0] if_pc_q;
    logic [31:0] if_inst_q;

    logic [31:0] target;
    logic [31:0] pc_inc;
    logic        req_pending;

    assign target      = {redirect_pc_i[31:2], 2'b00};
    assign pc_inc      = pc_q + 32'd4;
    // A request is stuck on the bus until acked; its address must not move.
    assign req_pending = (state_q == FETCH) && !imem_ack_i;

    assign imem_req_o    = (state_q == FETCH);
    assign imem_addr_o   = pc_q;
    assign if_valid_o    = if_valid_q;
    assign if_pc_o       = if_pc_q;
    assign if_inst_o     = if_inst_q;
    assign flush_if_id_o = redirect_i;
    assign flush_id_ex_o = redirect_i;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= BOOT;
            pc_q        <= RESET_PC;
            redir_q     <= 32'd0;
            drop_q      <= 1'b0;
            buf_valid_q <= 1'b0;
            buf_pc_q    <= 32'd0;
            buf_inst_q  <= 32'd0;
            if_valid_q  <= 1'b0;
            if_pc_q     <= 32'd0;
            if_inst_q   <= 32'd0;
        end else if (redirect_i) begin
            // The branch is older than anything held here, so it beats a stall.
            if_valid_q  <= 1'b0;
            buf_valid_q <= 1'b0;
            state_q     <= FETCH;
            if (req_pending) begin
                redir_q <= target;
                drop_q  <= 1'b1;
            end else begin
                pc_q   <= target;
                drop_q <= 1'b0;
            end
        end else begin
            case (state_q)
                BOOT: begin
                    state_q <= FETCH;
                end
                FETCH: begin
                    if (imem_ack_i) begin
                        if (drop_q) begin
                            pc_q   <= redir_q;
                            drop_q <= 1'b0;
                            if (!stall_i) begin
                                if_valid_q <= 1'b0;
                            end
                        end else if (!stall_i) begin
                            if_valid_q <= 1'b1;
                            if_pc_q    <= pc_q;
                            if_inst_q  <= imem_rdata_i;
                            pc_q       <= pc_inc;
                        end else begin
                            buf_valid_q <= 1'b1;
                            buf_pc_q    <= pc_q;
                            buf_inst_q  <= imem_rdata_i;
                            pc_q        <= pc_inc;
                            state_q     <= HOLD;
                        end
                    end else if (!stall_i) begin
                        if_valid_q <= 1'b0;
                    end
                end
                HOLD: begin
                    if (!stall_i) begin
                        if_valid_q  <= buf_valid_q;
                        if_pc_q     <= buf_pc_q;
                        if_inst_q   <= buf_inst_q;
                        buf_valid_q <= 1'b0;
                        state_q     <= FETCH;
                    end
                end
                default: begin
                    state_q <= BOOT;
                end
            endcase
        end
    end

endmodule
